// File: rtl/player_bullet.sv
// -----------------------------------------------------------------------------
// player_bullet
//
// Player projectile stage that sits after the ship sprite block. It launches a
// single bullet from the ship's nose when fire is requested, moves it up by
// SPEED pixels on every frame tick, and retires it on a hit or when it would
// leave the top of the screen. After a retirement the block waits
// COOLDOWN_FRAMES frame ticks before it can launch again.
//
// Ports
//   clk            pixel clock; all state lives in this domain
//   rst_n          asynchronous active-low reset
//   v_sync         vertical sync (clk domain); its rising edge is the frame tick
//   fire           debounced fire button level
//   ship_x_pos     ship left X
//   hit            collision logic reports the bullet struck a target
//   pix_x, pix_y   current beam position
//   bullet_active  bullet in flight
//   bullet_x       bullet left X (frozen at launch)
//   bullet_y       bullet top Y
//   bullet_on      beam is inside the active bullet box (combinational)
//   shot_fired     one-cycle pulse on launch
// -----------------------------------------------------------------------------
module player_bullet #(
    parameter int unsigned SPEED           = 6,
    parameter int unsigned BULLET_W        = 2,
    parameter int unsigned BULLET_H        = 6,
    parameter int unsigned SHIP_Y          = 440,
    parameter int unsigned SHIP_W          = 13,
    parameter int unsigned COOLDOWN_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       v_sync,
    input  logic       fire,
    input  logic [9:0] ship_x_pos,
    input  logic       hit,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic       bullet_active,
    output logic [9:0] bullet_x,
    output logic [9:0] bullet_y,
    output logic       bullet_on,
    output logic       shot_fired
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] FLYING   = 2'd1;
    localparam logic [1:0] COOLDOWN = 2'd2;

    // Counter must hold COOLDOWN_FRAMES; a value of 0 or 1 needs only one bit.
    localparam int unsigned CNT_W =
        (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

    localparam logic [9:0]       SPAWN_Y  = 10'(SHIP_Y - BULLET_H);
    localparam logic [9:0]       X_OFFSET = 10'(SHIP_W / 2 - BULLET_W / 2);
    localparam logic [9:0]       STEP_Y   = 10'(SPEED);
    localparam logic [10:0]      BOX_W    = 11'(BULLET_W);
    localparam logic [10:0]      BOX_H    = 11'(BULLET_H);
    localparam logic [CNT_W-1:0] CD_LOAD  = CNT_W'(COOLDOWN_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic             active_q, active_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             shot_q, shot_d;
    logic             v_sync_d;

    logic             tick;
    logic             launch;
    logic [9:0]       spawn_x;

    // -------------------------------------------------------------------------
    // Frame tick
    // -------------------------------------------------------------------------
    // v_sync_d resets high so a v_sync already high at reset release is not
    // mistaken for a rising edge.
    assign tick = v_sync & ~v_sync_d;

    // ship_x_pos is at most 627, so the spawn X fits in 10 bits.
    assign spawn_x = ship_x_pos + X_OFFSET;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        x_d       = x_q;
        y_d       = y_q;
        cnt_d     = cnt_q;
        pending_d = 1'b0;   // presses are not queued outside IDLE
        launch    = 1'b0;

        case (state_q)
            IDLE: begin
                // A press in the same cycle as the tick still launches.
                launch = tick & (pending_q | fire);
                if (launch) begin
                    state_d  = FLYING;
                    x_d      = spawn_x;
                    y_d      = SPAWN_Y;
                    active_d = 1'b1;
                end else begin
                    pending_d = pending_q | fire;
                end
            end

            FLYING: begin
                // Hit takes priority over a coincident tick: no move.
                if (hit) begin
                    state_d  = COOLDOWN;
                    active_d = 1'b0;
                    cnt_d    = CD_LOAD;
                end else if (tick) begin
                    // Test before subtracting so bullet_y never wraps.
                    if (y_q < STEP_Y) begin
                        state_d  = COOLDOWN;
                        active_d = 1'b0;
                        cnt_d    = CD_LOAD;
                    end else begin
                        y_d = y_q - STEP_Y;
                    end
                end
            end

            COOLDOWN: begin
                if (tick) begin
                    // <= 1 makes a zero load behave like one frame.
                    if (cnt_q <= CNT_ONE) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end

            default: begin
                state_d  = IDLE;
                active_d = 1'b0;
            end
        endcase
    end

    assign shot_d = launch;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            active_q  <= 1'b0;
            x_q       <= 10'd0;
            y_q       <= 10'd0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            shot_q    <= 1'b0;
            v_sync_d  <= 1'b1;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            shot_q    <= shot_d;
            v_sync_d  <= v_sync;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bullet_active = active_q;
    assign bullet_x      = x_q;
    assign bullet_y      = y_q;
    assign shot_fired    = shot_q;

    // Box test in 11 bits so the right/bottom edges cannot overflow.
    always_comb begin
        bullet_on = active_q
                 && ({1'b0, pix_x} >= {1'b0, x_q})
                 && ({1'b0, pix_x} <  ({1'b0, x_q} + BOX_W))
                 && ({1'b0, pix_y} >= {1'b0, y_q})
                 && ({1'b0, pix_y} <  ({1'b0, y_q} + BOX_H));
    end

endmodule

// File: tb/tb_player_bullet.sv
// Directed bench for player_bullet with hand-computed expectations.
module tb_player_bullet;

    logic       clk;
    logic       rst_n;
    logic       v_sync;
    logic       fire;
    logic [9:0] ship_x_pos;
    logic       hit;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       bullet_active;
    logic [9:0] bullet_x;
    logic [9:0] bullet_y;
    logic       bullet_on;
    logic       shot_fired;

    int checks;
    int errors;
    int shots;

    player_bullet dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .v_sync        (v_sync),
        .fire          (fire),
        .ship_x_pos    (ship_x_pos),
        .hit           (hit),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .bullet_active (bullet_active),
        .bullet_x      (bullet_x),
        .bullet_y      (bullet_y),
        .bullet_on     (bullet_on),
        .shot_fired    (shot_fired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count launch pulses seen on the output.
    always @(posedge clk) begin
        if (rst_n && shot_fired) shots <= shots + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs and samples sit 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Rising edge of v_sync seen by one clock edge, then v_sync drops.
    task automatic tick_hi();
        v_sync = 1'b1;
        step();
    endtask

    task automatic tick_lo();
        v_sync = 1'b0;
        step();
    endtask

    task automatic do_tick();
        tick_hi();
        tick_lo();
    endtask

    initial begin
        int base;
        checks     = 0;
        errors     = 0;
        shots      = 0;
        rst_n      = 1'b0;
        v_sync     = 1'b1;
        fire       = 1'b0;
        hit        = 1'b0;
        ship_x_pos = 10'd312;
        pix_x      = 10'd0;
        pix_y      = 10'd0;

        // Reset state
        #12;
        check("rst_active", bullet_active, 0);
        check("rst_x", bullet_x, 0);
        check("rst_y", bullet_y, 0);
        check("rst_shot", shot_fired, 0);
        check("rst_on", bullet_on, 0);

        // Release reset with v_sync already high: no tick, no launch.
        @(negedge clk);
        rst_n = 1'b1;
        fire  = 1'b1;
        step();
        step();
        check("vs_high_no_launch", bullet_active, 0);
        check("vs_high_no_shot", shots, 0);
        fire = 1'b0;
        v_sync = 1'b0;
        step();
        step();

        // Fire press pulse then one tick launches from ship_x_pos=312.
        fire = 1'b1;
        step();
        fire = 1'b0;
        step();
        tick_hi();
        check("launch_shot", shot_fired, 1);
        check("launch_active", bullet_active, 1);
        check("launch_x", bullet_x, 317);
        check("launch_y", bullet_y, 434);
        tick_lo();
        check("shot_one_cycle", shot_fired, 0);
        check("shot_count1", shots, 1);

        // bullet_on box at launch position (317..318, 434..439)
        pix_x = 10'd317; pix_y = 10'd434; #1;
        check("on_317_434", bullet_on, 1);
        pix_x = 10'd318; pix_y = 10'd439; #1;
        check("on_318_439", bullet_on, 1);
        pix_x = 10'd319; pix_y = 10'd434; #1;
        check("on_319_434", bullet_on, 0);
        pix_x = 10'd317; pix_y = 10'd440; #1;
        check("on_317_440", bullet_on, 0);

        // Ship moves; bullet X stays frozen.
        ship_x_pos = 10'd400;
        for (int k = 1; k <= 72; k++) begin
            do_tick();
            check("fly_y", bullet_y, 434 - 6 * k);
        end
        check("x_frozen", bullet_x, 317);
        check("fly_active", bullet_active, 1);

        // y=2 < 6: next tick retires, y holds.
        do_tick();
        check("retire_active", bullet_active, 0);
        check("retire_y", bullet_y, 2);

        // Fire held through cooldown: 8 ticks with no launch, then launch.
        fire = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            do_tick();
            check("cd_no_launch", bullet_active, 0);
        end
        check("cd_shot_count", shots, 1);
        tick_hi();
        check("relaunch_shot", shot_fired, 1);
        check("relaunch_x", bullet_x, 405);
        check("relaunch_y", bullet_y, 434);
        tick_lo();
        check("shot_count2", shots, 2);

        // Fly to y=200 with fire still held: no extra launches.
        for (int k = 1; k <= 39; k++) do_tick();
        check("pre_hit_y", bullet_y, 200);
        check("held_fire_no_extra", shots, 2);

        // Hit coincident with tick: hit wins, no move.
        hit    = 1'b1;
        v_sync = 1'b1;
        step();
        hit = 1'b0;
        check("hit_active", bullet_active, 0);
        check("hit_y", bullet_y, 200);
        check("hit_on", bullet_on, 0);
        tick_lo();

        // In COOLDOWN: hit is ignored, 8 ticks then relaunch on the 9th.
        base = shots;
        for (int k = 1; k <= 8; k++) begin
            hit = (k == 3);
            do_tick();
            check("hit_cd_no_launch", bullet_active, 0);
        end
        hit = 1'b0;
        check("hit_cd_y_hold", bullet_y, 200);
        do_tick();
        check("hit_relaunch", bullet_active, 1);
        check("shot_count3", shots, base + 1);
        fire = 1'b0;

        // Reset mid-flight clears bullet_on immediately.
        pix_x = 10'd405; pix_y = 10'd434; #1;
        check("pre_rst_on", bullet_on, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_on", bullet_on, 0);
        check("rst_mid_active", bullet_active, 0);
        step();
        rst_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
